// File: rtl/tiamc1_nvram_ioctl.sv
// tiamc1_nvram_ioctl: HPS ioctl responder for the NVRAM / high-score buffer.
// Owns a 2**AW byte single-port RAM shared with the tiamc1 CPU. The CPU port
// always wins the RAM, and ioctl_wait stalls the HPS side while a request is
// pending. Optional build macro: NVRAM_DIRTY_EN (buffer-changed tracking).
module tiamc1_nvram_ioctl #(
  parameter int         AW       = 11,
  parameter logic [7:0] NV_INDEX = 8'd4,
  parameter logic [7:0] FILL     = 8'hFF
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic [24:0]   ioctl_addr,
  input  logic          ioctl_rd,
  input  logic          ioctl_wr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          nvram_dirty
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DATA  = 2'd2,
    WR_ISSUE = 2'd3
  } state_t;

  logic [7:0]    mem_r [DEPTH];
  state_t        state_r;
  logic [24:0]   addr_r;
  logic [7:0]    data_r;
  logic [7:0]    ram_q_r;
  logic [7:0]    ioctl_din_r;
  logic          ioctl_wait_r;
  logic [7:0]    cpu_dout_r;

  logic          sel_s;
  logic          rd_req_s;
  logic          wr_req_s;
  logic          in_range_s;
  logic          ram_we_s;
  logic [AW-1:0] ram_addr_s;
  logic [7:0]    ram_wdata_s;

  assign sel_s      = (ioctl_index == NV_INDEX);
  assign rd_req_s   = ioctl_rd & ioctl_upload & sel_s;
  assign wr_req_s   = ioctl_wr & ioctl_download & sel_s;
  // Address bits above the RAM only decide whether the access is in range.
  assign in_range_s = (addr_r[24:AW] == {(25 - AW){1'b0}});

  // Single RAM port: CPU first, otherwise a pending in-range ioctl write.
  always_comb begin
    ram_addr_s  = addr_r[AW-1:0];
    ram_we_s    = 1'b0;
    ram_wdata_s = data_r;
    if (cpu_cs) begin
      ram_addr_s  = cpu_addr;
      ram_we_s    = cpu_we;
      ram_wdata_s = cpu_din;
    end else if ((state_r == WR_ISSUE) && in_range_s) begin
      ram_we_s    = 1'b1;
    end else begin
      ram_we_s    = 1'b0;
    end
  end

  // RAM array and ioctl-side read register; contents survive reset.
  always_ff @(posedge clk_sys) begin
    if (ram_we_s) begin
      mem_r[ram_addr_s] <= ram_wdata_s;
    end
    ram_q_r <= mem_r[ram_addr_s];
  end

  // CPU read data, read-before-write, held between CPU accesses.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cpu_dout_r <= 8'h00;
    end else if (cpu_cs) begin
      cpu_dout_r <= mem_r[cpu_addr];
    end
  end

  // Request FSM: accept in IDLE, yield to the CPU while issuing, then release wait.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      addr_r       <= 25'd0;
      data_r       <= 8'h00;
      ioctl_din_r  <= 8'h00;
      ioctl_wait_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rd_req_s) begin
            addr_r       <= ioctl_addr;
            ioctl_wait_r <= 1'b1;
            state_r      <= RD_ISSUE;
          end else if (wr_req_s) begin
            addr_r       <= ioctl_addr;
            data_r       <= ioctl_dout;
            ioctl_wait_r <= 1'b1;
            state_r      <= WR_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (!cpu_cs) begin
            state_r <= RD_DATA;
          end
        end
        RD_DATA: begin
          ioctl_din_r  <= in_range_s ? ram_q_r : FILL;
          ioctl_wait_r <= 1'b0;
          state_r      <= IDLE;
        end
        WR_ISSUE: begin
          if (!cpu_cs) begin
            ioctl_wait_r <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          ioctl_wait_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign ioctl_din  = ioctl_din_r;
  assign ioctl_wait = ioctl_wait_r;
  assign cpu_dout   = cpu_dout_r;

`ifdef NVRAM_DIRTY_EN
  logic upload_d_r;
  logic download_d_r;
  logic dirty_r;
  logic dirty_set_s;
  logic dirty_clr_s;

  assign dirty_set_s = cpu_cs & cpu_we;
  assign dirty_clr_s = sel_s & ((upload_d_r & ~ioctl_upload) |
                                (download_d_r & ~ioctl_download));

  // Session-end edge detect; a CPU write in the same cycle keeps the buffer dirty.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      upload_d_r   <= 1'b0;
      download_d_r <= 1'b0;
      dirty_r      <= 1'b0;
    end else begin
      upload_d_r   <= ioctl_upload;
      download_d_r <= ioctl_download;
      if (dirty_set_s) begin
        dirty_r <= 1'b1;
      end else if (dirty_clr_s) begin
        dirty_r <= 1'b0;
      end
    end
  end

  assign nvram_dirty = dirty_r;
`else
  assign nvram_dirty = 1'b0;
`endif

endmodule

// File: tb/tb_tiamc1_nvram_ioctl.sv
// Scoreboard bench for tiamc1_nvram_ioctl: stimulus pushes expected ioctl
// completions and CPU read data; a negedge monitor pops and compares.
module tb_tiamc1_nvram_ioctl;

  localparam logic [7:0] NV = 8'd4;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic        ioctl_rd = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        cpu_cs = 1'b0;
  logic        cpu_we = 1'b0;
  logic [10:0] cpu_addr = 11'd0;
  logic [7:0]  cpu_din = 8'd0;
  logic [7:0]  cpu_dout;
  logic        nvram_dirty;

  tiamc1_nvram_ioctl dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .nvram_dirty(nvram_dirty)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct { logic is_rd; logic [7:0] data; int lat; int issue; } io_exp_t;
  typedef struct { logic chk; logic [7:0] data; } cpu_exp_t;
  io_exp_t  ioq[$];
  cpu_exp_t cpuq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: ioctl completion on falling wait, CPU data the cycle after cpu_cs.
  logic wait_prev = 1'b0;
  logic cpu_pend = 1'b0;
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      wait_prev = 1'b0;
      cpu_pend  = 1'b0;
    end else begin
      if (!wait_prev && ioctl_wait && ioq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_wait: got wait=1 expected 0 (t=%0t)", $time);
      end
      if (wait_prev && !ioctl_wait) begin
        if (ioq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          io_exp_t e;
          e = ioq.pop_front();
          chk("io_latency", cyc - e.issue, e.lat);
          if (e.is_rd) chk("ioctl_din", ioctl_din, e.data);
        end
      end
      wait_prev = ioctl_wait;
      if (cpu_pend) begin
        if (cpuq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cpu: got access expected none");
        end else begin
          cpu_exp_t c;
          c = cpuq.pop_front();
          if (c.chk) chk("cpu_dout", cpu_dout, c.data);
        end
      end
      cpu_pend = cpu_cs;
    end
  end

  // All tasks start and end at #1 after a rising edge.
  task automatic io_issue(input logic rd, input logic wr, input logic [7:0] idx,
                          input logic [24:0] addr, input logic [7:0] d);
    ioctl_index = idx; ioctl_addr = addr; ioctl_dout = d;
    ioctl_rd = rd; ioctl_wr = wr;
    if (rd) ioctl_upload = 1'b1;
    if (wr) ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0; ioctl_wr = 1'b0;
  endtask

  task automatic expect_io(input logic is_rd, input logic [7:0] d, input int lat);
    io_exp_t e;
    e.is_rd = is_rd; e.data = d; e.lat = lat; e.issue = cyc;
    ioq.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (ioq.size() == 0) break;
      @(posedge clk_sys); #1;
    end
    if (ioq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", ioq.size());
      ioq.delete();
    end
  endtask

  task automatic io_rd(input logic [24:0] addr, input logic [7:0] exp);
    expect_io(1'b1, exp, 3);
    io_issue(1'b1, 1'b0, NV, addr, 8'h00);
    drain();
  endtask

  task automatic io_wr(input logic [24:0] addr, input logic [7:0] d);
    expect_io(1'b0, 8'h00, 2);
    io_issue(1'b0, 1'b1, NV, addr, d);
    drain();
  endtask

  task automatic cpu_acc(input logic we, input logic [10:0] addr, input logic [7:0] d,
                         input logic chk_en, input logic [7:0] exp);
    cpu_exp_t c;
    c.chk = chk_en; c.data = exp;
    cpuq.push_back(c);
    cpu_cs = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = d;
    @(posedge clk_sys); #1;
    cpu_cs = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys); #1;
    end
  endtask

  initial begin
    logic [7:0] restore [4];
    restore[0] = 8'h11; restore[1] = 8'h22; restore[2] = 8'h33; restore[3] = 8'h44;

    // Reset state
    @(posedge clk_sys); @(posedge clk_sys); #1;
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_din", ioctl_din, 0);
    chk("rst_cpu_dout", cpu_dout, 0);
    chk("rst_dirty", nvram_dirty, 0);
    reset_n = 1'b1;
    idle(2);

    // Restore download, then CPU read-back
    for (int i = 0; i < 4; i++) io_wr(25'(i), restore[i]);
    for (int i = 0; i < 4; i++) cpu_acc(1'b0, 11'(i), 8'h00, 1'b1, restore[i]);
    idle(2);

    // Upload of a CPU-written byte, then upload of the restored bytes
    cpu_acc(1'b1, 11'h010, 8'hA5, 1'b0, 8'h00);
    io_rd(25'h010, 8'hA5);
    for (int i = 0; i < 4; i++) io_rd(25'(i), restore[i]);

    // Contention: CPU reads three cycles right after the strobe
    expect_io(1'b1, 8'hA5, 6);
    io_issue(1'b1, 1'b0, NV, 25'h010, 8'h00);
    cpu_acc(1'b0, 11'd0, 8'h00, 1'b1, 8'h11);
    cpu_acc(1'b0, 11'd1, 8'h00, 1'b1, 8'h22);
    cpu_acc(1'b0, 11'd2, 8'h00, 1'b1, 8'h33);
    drain();

    // CPU read-before-write on the same address
    cpu_acc(1'b1, 11'd3, 8'h55, 1'b1, 8'h44);
    cpu_acc(1'b0, 11'd3, 8'h00, 1'b1, 8'h55);
    idle(1);

    // Out of range: fill byte on read, write dropped (no alias onto addr 0)
    io_rd(25'h800, 8'hFF);
    io_wr(25'h800, 8'h77);
    cpu_acc(1'b0, 11'd0, 8'h00, 1'b1, 8'h11);
    io_rd(25'h000, 8'h11);

    // Wrong index: no wait, no RAM change, din held
    io_issue(1'b1, 1'b0, 8'd3, 25'h010, 8'h00);
    idle(4);
    chk("badidx_wait", ioctl_wait, 0);
    chk("badidx_din_hold", ioctl_din, 8'h11);
    io_issue(1'b0, 1'b1, 8'd3, 25'd1, 8'h99);
    idle(3);
    cpu_acc(1'b0, 11'd1, 8'h00, 1'b1, 8'h22);

    // Simultaneous rd and wr: read wins, write dropped
    expect_io(1'b1, 8'h33, 3);
    io_issue(1'b1, 1'b1, NV, 25'd2, 8'hEE);
    drain();
    cpu_acc(1'b0, 11'd2, 8'h00, 1'b1, 8'h33);
    idle(1);

    // Reset in RD_ISSUE: outputs clear at once, RAM retained
    io_rd(25'h800, 8'hFF);
    io_issue(1'b1, 1'b0, NV, 25'h010, 8'h00);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_wait", ioctl_wait, 0);
    chk("midrst_din", ioctl_din, 0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    idle(1);
    io_rd(25'h010, 8'hA5);
    cpu_acc(1'b0, 11'd0, 8'h00, 1'b1, 8'h11);
    idle(1);

`ifdef NVRAM_DIRTY_EN
    ioctl_index = NV; ioctl_upload = 1'b0; ioctl_download = 1'b0;
    idle(2);
    chk("dirty_after_restore_end", nvram_dirty, 0);
    cpu_acc(1'b1, 11'h020, 8'h01, 1'b0, 8'h00);
    chk("dirty_set", nvram_dirty, 1);
    ioctl_upload = 1'b1;
    idle(1);
    ioctl_upload = 1'b0;
    idle(1);
    chk("dirty_clear", nvram_dirty, 0);
    ioctl_upload = 1'b1;
    idle(1);
    ioctl_upload = 1'b0;
    cpu_acc(1'b1, 11'h020, 8'h02, 1'b1, 8'h01);
    chk("dirty_set_wins", nvram_dirty, 1);
`else
    cpu_acc(1'b1, 11'h020, 8'h01, 1'b0, 8'h00);
    idle(1);
    chk("dirty_tied_low", nvram_dirty, 0);
`endif

    idle(4);
    chk("ioq_empty", ioq.size(), 0);
    chk("cpuq_empty", cpuq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
